// File: rtl/y86_pkg.sv
// Y86-64 shared pipeline encodings.
// Stat codes, icodes, register IDs and the D/E bundle.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } id_ex_t;

    localparam id_ex_t ID_EX_NOP = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valc:  64'h0,
        vala:  64'h0,
        valb:  64'h0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

endpackage

// File: rtl/regfile.sv
// Y86-64 register file: 15x64, two read, two write ports.
// The valM port overrides valE when both hit one register.
module regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [0:14];

    // Storage: clear on reset, E write then M write so M wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= 64'h0;
            end
        end else begin
            if (dst_e != RNONE) begin
                regs[dst_e] <= val_e;
            end
            if (dst_m != RNONE) begin
                regs[dst_m] <= val_m;
            end
        end
    end

    // Read ports: RNONE reads as zero.
    always_comb begin
        val_a = 64'h0;
        val_b = 64'h0;
        if (src_a != RNONE) begin
            val_a = regs[src_a];
        end
        if (src_b != RNONE) begin
            val_b = regs[src_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage with forwarding and D/E latch.
// Register file is written from W here.
module decode_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [2:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);

    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] rf_a;
    logic [63:0] rf_b;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    id_ex_t      d_bundle;
    id_ex_t      e_q;

    regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .val_a (rf_a),
        .val_b (rf_b),
        .dst_e (W_dstE),
        .val_e (W_valE),
        .dst_m (W_dstM),
        .val_m (W_valM)
    );

    // Youngest stage first; RNONE never matches.
    function automatic logic [63:0] fwd(
        input logic [3:0]  src,
        input logic [63:0] rf_val,
        input logic [3:0]  ex_dste,
        input logic [63:0] ex_vale,
        input logic [3:0]  mem_dstm,
        input logic [63:0] mem_valm,
        input logic [3:0]  mem_dste,
        input logic [63:0] mem_vale,
        input logic [3:0]  wb_dstm,
        input logic [63:0] wb_valm,
        input logic [3:0]  wb_dste,
        input logic [63:0] wb_vale
    );
        logic [63:0] r;
        r = rf_val;
        if (src == RNONE)         r = 64'h0;
        else if (src == ex_dste)  r = ex_vale;
        else if (src == mem_dstm) r = mem_valm;
        else if (src == mem_dste) r = mem_vale;
        else if (src == wb_dstm)  r = wb_valm;
        else if (src == wb_dste)  r = wb_vale;
        return r;
    endfunction

    // Register ID decode from icode.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin
                d_srcA = D_rA;
                d_dstE = D_rB;
            end
            I_IRMOVQ: begin
                d_dstE = D_rB;
            end
            I_RMMOVQ: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
            end
            I_MRMOVQ: begin
                d_srcB = D_rB;
                d_dstM = D_rA;
            end
            I_OPQ: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
                d_dstE = D_rB;
            end
            I_CALL: begin
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_RET: begin
                d_srcA = RSP;
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_PUSHQ: begin
                d_srcA = D_rA;
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_POPQ: begin
                d_srcA = RSP;
                d_srcB = RSP;
                d_dstE = RSP;
                d_dstM = D_rA;
            end
            default: begin
            end
        endcase
    end

    // Operand selection: valP for CALL/JXX, else forwarded.
    always_comb begin
        d_valB = fwd(d_srcB, rf_b,
                     e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM,
                     W_dstE, W_valE);
        if (D_icode == I_CALL || D_icode == I_JXX) begin
            d_valA = D_valP;
        end else begin
            d_valA = fwd(d_srcA, rf_a,
                         e_dstE, e_valE, M_dstM, m_valM,
                         M_dstE, M_valE, W_dstM, W_valM,
                         W_dstE, W_valE);
        end
    end

    // Bundle assembly for the E latch.
    always_comb begin
        d_bundle       = ID_EX_NOP;
        d_bundle.stat  = D_stat;
        d_bundle.icode = D_icode;
        d_bundle.ifun  = D_ifun;
        d_bundle.valc  = D_valC;
        d_bundle.vala  = d_valA;
        d_bundle.valb  = d_valB;
        d_bundle.dste  = d_dstE;
        d_bundle.dstm  = d_dstM;
        d_bundle.srca  = d_srcA;
        d_bundle.srcb  = d_srcB;
    end

    // D/E pipeline register; bubble and reset load a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= ID_EX_NOP;
        end else if (E_bubble) begin
            e_q <= ID_EX_NOP;
        end else begin
            e_q <= d_bundle;
        end
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage.
// Vectors run in order; register state carries over.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        bub;
        logic [3:0]  edst;
        logic [63:0] eval;
        logic [3:0]  mdste, mdstm;
        logic [63:0] mvale, mvalm;
        logic [3:0]  wdste, wdstm;
        logic [63:0] wvale, wvalm;
        logic [3:0]  x_srca, x_srcb;
        logic [2:0]  x_stat;
        logic [3:0]  x_icode;
        logic [63:0] x_vala, x_valb;
        logic [3:0]  x_dste, x_dstm;
    } vec_t;

    vec_t v [15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0;
        D_rA = 4'hF; D_rB = 4'hF; D_valC = '0; D_valP = '0;
        E_bubble = 1'b0;
        e_dstE = 4'hF; e_valE = '0;
        M_dstE = 4'hF; M_dstM = 4'hF; M_valE = '0; m_valM = '0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = '0; W_valM = '0;
    endtask

    function automatic vec_t mk(
        input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
        input logic [3:0] rb, input logic [63:0] valp, input logic bub,
        input logic [3:0] xsa, input logic [3:0] xsb, input logic [2:0] xst,
        input logic [3:0] xic, input logic [63:0] xa, input logic [63:0] xb,
        input logic [3:0] xde, input logic [3:0] xdm);
        vec_t r;
        r.stat = st; r.icode = ic; r.ifun = 4'h3; r.ra = ra; r.rb = rb;
        r.valc = 64'h0000_5000 + {60'h0, ic}; r.valp = valp; r.bub = bub;
        r.edst = 4'hF; r.eval = 64'hDEAD;
        r.mdste = 4'hF; r.mdstm = 4'hF; r.mvale = 64'h0; r.mvalm = 64'h0;
        r.wdste = 4'hF; r.wdstm = 4'hF; r.wvale = 64'h0; r.wvalm = 64'h0;
        r.x_srca = xsa; r.x_srcb = xsb; r.x_stat = xst; r.x_icode = xic;
        r.x_vala = xa; r.x_valb = xb; r.x_dste = xde; r.x_dstm = xdm;
        return r;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // 0: nop, nothing written
        v[0] = mk(1, 4'h1, 4'hF, 4'hF, 0, 0, 4'hF, 4'hF, 1, 4'h1,
                  0, 0, 4'hF, 4'hF);
        // 1: opq r0,r1 reads zero; W writes r3=0x1234
        v[1] = mk(1, 4'h6, 4'h0, 4'h1, 0, 0, 4'h0, 4'h1, 1, 4'h6,
                  0, 0, 4'h1, 4'hF);
        v[1].wdste = 4'h3; v[1].wvale = 64'h1234;
        // 2: opq r3,r3 sees written value
        v[2] = mk(1, 4'h6, 4'h3, 4'h3, 0, 0, 4'h3, 4'h3, 1, 4'h6,
                  64'h1234, 64'h1234, 4'h3, 4'hF);
        // 3: rrmovq r2: e beats M beats W
        v[3] = mk(1, 4'h2, 4'h2, 4'h6, 0, 0, 4'h2, 4'hF, 1, 4'h2,
                  64'hAA, 0, 4'h6, 4'hF);
        v[3].edst = 4'h2; v[3].eval = 64'hAA;
        v[3].mdste = 4'h2; v[3].mvale = 64'hBB;
        v[3].wdste = 4'h2; v[3].wvale = 64'hCC;
        // 4: e idle -> M_valE
        v[4] = v[3];
        v[4].edst = 4'hF; v[4].x_vala = 64'hBB;
        // 5: no forwards, r2 now holds CC
        v[5] = mk(1, 4'h2, 4'h2, 4'h6, 0, 0, 4'h2, 4'hF, 1, 4'h2,
                  64'hCC, 0, 4'h6, 4'hF);
        // 6: m_valM beats M_valE
        v[6] = mk(1, 4'h6, 4'h7, 4'h7, 0, 0, 4'h7, 4'h7, 1, 4'h6,
                  64'h55, 64'h55, 4'h7, 4'hF);
        v[6].mdstm = 4'h7; v[6].mvalm = 64'h55;
        v[6].mdste = 4'h7; v[6].mvale = 64'h66;
        // 7: W_valM beats W_valE; r8 gets 0x77
        v[7] = mk(1, 4'h6, 4'h8, 4'h9, 0, 0, 4'h8, 4'h9, 1, 4'h6,
                  64'h77, 0, 4'h9, 4'hF);
        v[7].wdstm = 4'h8; v[7].wvalm = 64'h77;
        v[7].wdste = 4'h8; v[7].wvale = 64'h88;
        // 8: call valP=0x40; W writes r4 both ports
        v[8] = mk(1, 4'h8, 4'hF, 4'hF, 64'h40, 0, 4'hF, 4'h4, 1, 4'h8,
                  64'h40, 64'h2, 4'h4, 4'hF);
        v[8].wdste = 4'h4; v[8].wvale = 64'h1;
        v[8].wdstm = 4'h4; v[8].wvalm = 64'h2;
        // 9: popq r5, r4 holds 2
        v[9] = mk(1, 4'hB, 4'h5, 4'hF, 0, 0, 4'h4, 4'h4, 1, 4'hB,
                  64'h2, 64'h2, 4'h4, 4'h5);
        // 10: r8 holds valM from same-register write
        v[10] = mk(1, 4'h6, 4'h8, 4'h8, 0, 0, 4'h8, 4'h8, 1, 4'h6,
                   64'h77, 64'h77, 4'h8, 4'hF);
        // 11: jxx valP; RNONE ignores e forward
        v[11] = mk(1, 4'h7, 4'hF, 4'hF, 64'h99, 0, 4'hF, 4'hF, 1, 4'h7,
                   64'h99, 0, 4'hF, 4'hF);
        v[11].edst = 4'hF; v[11].eval = 64'hDEAD;
        // 12: mrmovq bubbled -> NOP bundle
        v[12] = mk(2, 4'h5, 4'h1, 4'h3, 0, 1, 4'hF, 4'h3, 1, 4'h1,
                   0, 0, 4'hF, 4'hF);
        // 13: same mrmovq, not bubbled
        v[13] = mk(2, 4'h5, 4'h1, 4'h3, 0, 0, 4'hF, 4'h3, 2, 4'h5,
                   0, 64'h1234, 4'hF, 4'h1);
        // 14: pushq r3
        v[14] = mk(1, 4'hA, 4'h3, 4'hF, 0, 0, 4'h3, 4'h4, 1, 4'hA,
                   64'h1234, 64'h2, 4'h4, 4'hF);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_icode", E_icode, 4'h1);
        chk("rst_stat", E_stat, 3'd1);
        chk("rst_dstE", E_dstE, 4'hF);
        chk("rst_valA", E_valA, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            D_stat = v[i].stat; D_icode = v[i].icode; D_ifun = v[i].ifun;
            D_rA = v[i].ra; D_rB = v[i].rb;
            D_valC = v[i].valc; D_valP = v[i].valp;
            E_bubble = v[i].bub;
            e_dstE = v[i].edst; e_valE = v[i].eval;
            M_dstE = v[i].mdste; M_dstM = v[i].mdstm;
            M_valE = v[i].mvale; m_valM = v[i].mvalm;
            W_dstE = v[i].wdste; W_dstM = v[i].wdstm;
            W_valE = v[i].wvale; W_valM = v[i].wvalm;
            #1;
            chk($sformatf("v%0d_srcA", i), d_srcA, v[i].x_srca);
            chk($sformatf("v%0d_srcB", i), d_srcB, v[i].x_srcb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_stat", i), E_stat, v[i].x_stat);
            chk($sformatf("v%0d_icode", i), E_icode, v[i].x_icode);
            chk($sformatf("v%0d_ifun", i), E_ifun,
                v[i].bub ? 4'h0 : v[i].ifun);
            chk($sformatf("v%0d_valC", i), E_valC,
                v[i].bub ? 64'h0 : v[i].valc);
            chk($sformatf("v%0d_valA", i), E_valA, v[i].x_vala);
            chk($sformatf("v%0d_valB", i), E_valB, v[i].x_valb);
            chk($sformatf("v%0d_dstE", i), E_dstE, v[i].x_dste);
            chk($sformatf("v%0d_dstM", i), E_dstM, v[i].x_dstm);
            chk($sformatf("v%0d_Esrc", i), {E_srcA, E_srcB},
                v[i].bub ? 8'hFF : {v[i].x_srca, v[i].x_srcb});
        end

        // Async reset between edges clears E immediately.
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_icode", E_icode, 4'h1);
        chk("arst_dstE", E_dstE, 4'hF);
        chk("arst_valA", E_valA, 64'h0);
        chk("arst_srcA", E_srcA, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // Registers cleared: opq r3,r4 reads zero.
        D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h4;
        @(posedge clk);
        #1;
        chk("post_rst_valA", E_valA, 64'h0);
        chk("post_rst_valB", E_valB, 64'h0);
        chk("post_rst_dstE", E_dstE, 4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
